pc_unit: RTL and testbench

Parametrised program-counter unit for the multicycle CPU. It holds the architectural PC and computes its next value from one of several sources: sequential increment, relative branch, absolute jump, return, exception entry and exception return. It also holds the exception PC (EPC), detects misaligned control-flow targets, and can optionally include a small return-address stack (RAS). The control FSM drives it and updates it only in the cycles that assert the write enable.

---
 rtl/pc_unit.sv | 150 +++++++++++++++
 tb/tb_pc_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | pc_unit : program counter with EPC, misalignment trap and optional RAS   |
// |           (return-address stack built when PC_UNIT_RAS_EN is defined)    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int               INC          = 4,
  parameter int               ALIGN_BITS   = 2,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             i_pc_unit_clk,
  input  logic             i_pc_unit_rst,
  input  logic             i_pc_unit_we,
  input  logic [2:0]       i_pc_unit_sel,
  input  logic [WIDTH-1:0] i_pc_unit_offset,
  input  logic [WIDTH-1:0] i_pc_unit_target,
  input  logic             i_pc_unit_call,
  output logic [WIDTH-1:0] o_pc_unit_pc,
  output logic [WIDTH-1:0] o_pc_unit_next,
  output logic [WIDTH-1:0] o_pc_unit_epc,
  output logic             o_pc_unit_fault,
  output logic             o_pc_unit_ras_empty,
  output logic             o_pc_unit_ras_full
);

  localparam logic [2:0] c_SEL_INC    = 3'd0;
  localparam logic [2:0] c_SEL_BRANCH = 3'd1;
  localparam logic [2:0] c_SEL_JUMP   = 3'd2;
  localparam logic [2:0] c_SEL_RETURN = 3'd3;
  localparam logic [2:0] c_SEL_EXC    = 3'd4;
  localparam logic [2:0] c_SEL_ERET   = 3'd5;

  localparam logic [WIDTH-1:0] c_INC        = WIDTH'(INC);
  localparam logic [WIDTH-1:0] c_ALIGN_MASK = ~({WIDTH{1'b1}} << ALIGN_BITS);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic             r_fault;

  logic [WIDTH-1:0] w_cand;
  logic             w_chk;
  logic             w_mis;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;

  always_comb begin
    w_cand = r_pc;
    w_chk  = 1'b0;
    case (i_pc_unit_sel)
      c_SEL_INC:    w_cand = r_pc + c_INC;
      c_SEL_BRANCH: begin w_cand = r_pc + i_pc_unit_offset; w_chk = 1'b1; end
      c_SEL_JUMP:   begin w_cand = i_pc_unit_target;        w_chk = 1'b1; end
      c_SEL_RETURN: begin
        w_cand = w_ras_empty ? i_pc_unit_target : w_ras_top;
        w_chk  = 1'b1;
      end
      c_SEL_EXC:    w_cand = EXC_VECTOR;
      c_SEL_ERET:   begin w_cand = r_epc; w_chk = 1'b1; end
      default:      w_cand = r_pc;
    endcase
  end

  // A misaligned control-flow target is redirected to the exception vector.
  assign w_mis  = w_chk && (|(w_cand & c_ALIGN_MASK));
  assign w_next = w_mis ? EXC_VECTOR : w_cand;

  always_ff @(posedge i_pc_unit_clk or posedge i_pc_unit_rst) begin
    if (i_pc_unit_rst) begin
      r_pc    <= RESET_VECTOR;
      r_epc   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= i_pc_unit_we && w_mis;
      if (i_pc_unit_we) begin
        r_pc <= w_next;
        if (w_mis || (i_pc_unit_sel == c_SEL_EXC))
          r_epc <= r_pc;
      end
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam int c_PW = $clog2(RAS_DEPTH);
  localparam int c_CW = $clog2(RAS_DEPTH + 1);
  localparam logic [c_PW-1:0] c_LAST  = c_PW'(RAS_DEPTH - 1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_ras_mem [RAS_DEPTH];
  logic [c_PW-1:0]  r_ras_top;
  logic [c_CW-1:0]  r_ras_cnt;
  logic [c_PW-1:0]  w_top_inc;
  logic [c_PW-1:0]  w_top_dec;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_pc_unit_we && i_pc_unit_call && !w_mis &&
                  ((i_pc_unit_sel == c_SEL_BRANCH) || (i_pc_unit_sel == c_SEL_JUMP));
  assign w_pop  = i_pc_unit_we && !w_mis && !w_ras_empty &&
                  (i_pc_unit_sel == c_SEL_RETURN);

  assign w_top_inc   = (r_ras_top == c_LAST) ? '0 : r_ras_top + c_PW'(1);
  assign w_top_dec   = (r_ras_top == '0) ? c_LAST : r_ras_top - c_PW'(1);
  assign w_ras_top   = r_ras_mem[r_ras_top];
  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ras_full  = (r_ras_cnt == c_DEPTH);

  // Circular buffer: a push while full overwrites the oldest entry.
  always_ff @(posedge i_pc_unit_clk or posedge i_pc_unit_rst) begin
    if (i_pc_unit_rst) begin
      r_ras_top <= c_LAST;
      r_ras_cnt <= '0;
    end else if (w_push) begin
      r_ras_top <= w_top_inc;
      if (!w_ras_full)
        r_ras_cnt <= r_ras_cnt + c_CW'(1);
    end else if (w_pop) begin
      r_ras_top <= w_top_dec;
      r_ras_cnt <= r_ras_cnt - c_CW'(1);
    end
  end

  always_ff @(posedge i_pc_unit_clk) begin
    if (w_push)
      r_ras_mem[w_top_inc] <= r_pc + c_INC;
  end
`else
  logic w_unused_cfg;

  assign w_unused_cfg = i_pc_unit_call ^ (RAS_DEPTH == 0);
  assign w_ras_top    = '0;
  assign w_ras_empty  = 1'b1;
  assign w_ras_full   = 1'b0;
`endif

  assign o_pc_unit_pc        = r_pc;
  assign o_pc_unit_next      = w_next;
  assign o_pc_unit_epc       = r_epc;
  assign o_pc_unit_fault     = r_fault;
  assign o_pc_unit_ras_empty = w_ras_empty;
  assign o_pc_unit_ras_full  = w_ras_full;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_pc_unit : scoreboard bench for pc_unit against a queue-based model     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
  localparam bit c_RAS_ON = 1'b1;
`else
  localparam bit c_RAS_ON = 1'b0;
`endif
  localparam logic [31:0] c_EXC   = 32'h0000_0180;
  localparam int          c_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  sel = 3'd6;
  logic [31:0] offset = '0;
  logic [31:0] target = '0;
  logic        call = 1'b0;
  logic [31:0] pc, nxt, epc;
  logic        fault, ras_empty, ras_full;

  int checks = 0;
  int failures = 0;

  pc_unit #(
    .WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(c_EXC),
    .INC(4), .ALIGN_BITS(2), .RAS_DEPTH(c_DEPTH)
  ) dut (
    .i_pc_unit_clk(clk), .i_pc_unit_rst(rst), .i_pc_unit_we(we),
    .i_pc_unit_sel(sel), .i_pc_unit_offset(offset), .i_pc_unit_target(target),
    .i_pc_unit_call(call), .o_pc_unit_pc(pc), .o_pc_unit_next(nxt),
    .o_pc_unit_epc(epc), .o_pc_unit_fault(fault),
    .o_pc_unit_ras_empty(ras_empty), .o_pc_unit_ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] nxt;
    logic        fault;
    logic        empty;
    logic        full;
  } exp_t;
  exp_t q[$];

  // Reference state: PC, EPC and the return stack as a plain queue (newest at back).
  logic [31:0] m_pc = '0;
  logic [31:0] m_epc = '0;
  logic        m_fault = 1'b0;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_cand(input logic [2:0] s, input logic [31:0] off,
                                     input logic [31:0] tgt,
                                     output logic [31:0] cand, output logic mis);
    logic checked;
    checked = (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd5);
    case (s)
      3'd0:    cand = m_pc + 32'd4;
      3'd1:    cand = m_pc + off;
      3'd2:    cand = tgt;
      3'd3:    cand = (c_RAS_ON && m_ras.size() > 0) ? m_ras[m_ras.size()-1] : tgt;
      3'd4:    cand = c_EXC;
      3'd5:    cand = m_epc;
      default: cand = m_pc;
    endcase
    mis = checked && (cand % 4 != 0);
  endfunction

  task automatic step(input logic w, input logic [2:0] s, input logic [31:0] off,
                      input logic [31:0] tgt, input logic c);
    logic [31:0] cand;
    logic        mis;
    exp_t        e;
    @(negedge clk);
    we = w; sel = s; offset = off; target = tgt; call = c;
    model_cand(s, off, tgt, cand, mis);
    if (!w) begin
      m_fault = 1'b0;
    end else if (mis) begin
      m_epc   = m_pc;
      m_pc    = c_EXC;
      m_fault = 1'b1;
    end else begin
      m_fault = 1'b0;
      if (s == 3'd4) m_epc = m_pc;
      if (c_RAS_ON && c && (s == 3'd1 || s == 3'd2)) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > c_DEPTH) void'(m_ras.pop_front());
      end
      if (c_RAS_ON && s == 3'd3 && m_ras.size() > 0) void'(m_ras.pop_back());
      m_pc = cand;
    end
    // The preview after the edge reflects the new state with inputs still held.
    model_cand(s, off, tgt, cand, mis);
    e.pc    = m_pc;
    e.epc   = m_epc;
    e.fault = m_fault;
    e.nxt   = mis ? c_EXC : cand;
    e.empty = !c_RAS_ON || (m_ras.size() == 0);
    e.full  = c_RAS_ON && (m_ras.size() == c_DEPTH);
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("epc", epc, e.epc);
      chk("next", nxt, e.nxt);
      chk("fault", 32'(fault), 32'(e.fault));
      chk("ras_empty", 32'(ras_empty), 32'(e.empty));
      chk("ras_full", 32'(ras_full), 32'(e.full));
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_epc"}, epc, 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'h0);
    chk({tag, "_ras_empty"}, 32'(ras_empty), 32'h1);
    chk({tag, "_ras_full"}, 32'(ras_full), 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) a = a | 32'(($urandom_range(1, 3)));
    return a;
  endfunction

  initial begin
    #2;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    repeat (3) step(1'b1, 3'd0, '0, '0, 1'b0);

    step(1'b1, 3'd2, '0, 32'h100, 1'b0);
    step(1'b1, 3'd1, 32'hFFFF_FFF8, '0, 1'b0);
    step(1'b1, 3'd2, '0, 32'h2000, 1'b0);
    step(1'b1, 3'd2, '0, 32'hFFFF_FFFC, 1'b0);
    step(1'b1, 3'd0, '0, '0, 1'b0);

    step(1'b1, 3'd2, '0, 32'h40, 1'b0);
    step(1'b1, 3'd2, '0, 32'h1002, 1'b0);
    step(1'b1, 3'd5, '0, '0, 1'b0);
    step(1'b1, 3'd4, '0, '0, 1'b0);
    step(1'b1, 3'd5, '0, '0, 1'b0);

    step(1'b1, 3'd2, '0, 32'h0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b1, 3'd2, '0, 32'(i * 16), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 3'd3, '0, 32'h700, 1'b0);
    step(1'b1, 3'd3, '0, 32'h500, 1'b0);
    step(1'b1, 3'd1, 32'h10, '0, 1'b1);
    step(1'b1, 3'd3, '0, 32'h300, 1'b0);
    step(1'b1, 3'd2, '0, 32'h800, 1'b1);
    step(1'b1, 3'd3, '0, 32'h301, 1'b0);
    step(1'b1, 3'd1, 32'h6, '0, 1'b1);

    step(1'b1, 3'd6, '0, '0, 1'b0);
    step(1'b1, 3'd7, '0, '0, 1'b0);
    repeat (5) step(1'b0, 3'd4, '0, '0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      logic [31:0] off;
      off = (32'($urandom_range(0, 255)) - 32'd128) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) off = off | 32'h2;
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), off, rand_addr(),
           1'($urandom_range(0, 1)));
    end

    // Asynchronous reset between clock edges while a write is being presented.
    step(1'b1, 3'd2, '0, 32'h40, 1'b1);
    step(1'b1, 3'd0, '0, '0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    m_pc = '0; m_epc = '0; m_fault = 1'b0; m_ras.delete();
    @(negedge clk);
    rst = 1'b0;
    we  = 1'b0;
    repeat (3) step(1'b1, 3'd0, '0, '0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
